// File: rtl/vaddr_slot_pkg.sv
// Shared types and helpers for the virtual-address slot allocator.
// Addresses are computed at full 64-bit width and truncated by each user.
package vaddr_slot_pkg;

  localparam int unsigned MAX_ADDR_W = 64;

  typedef logic [MAX_ADDR_W-1:0] vaddr_t;

  localparam vaddr_t DEF_BASE   = 64'h0000_0000_0000_1000;
  localparam vaddr_t DEF_STRIDE = 64'h0000_0000_0000_0100;

  // Untruncated address of slot i; callers narrow it to their ADDR_W.
  function automatic vaddr_t slot_addr(input vaddr_t base, input vaddr_t stride,
                                       input int unsigned i);
    return base + vaddr_t'(i) * stride;
  endfunction

endpackage

// File: rtl/vaddr_slot_prio_enc.sv
// Lowest-set-bit finder: returns the index of the least significant set bit
// of vec and a flag saying whether any bit was set.
module vaddr_slot_prio_enc #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vaddr_slot_alloc.sv
// Virtual-address slot allocator: grants the lowest free slot and reclaims freed ones.
// Define VADDR_SLOT_ELAB_CHECK_EN to verify the address table at elaboration.
module vaddr_slot_alloc
  import vaddr_slot_pkg::*;
#(
  parameter int     NUM_SLOTS = 4,
  parameter int     ADDR_W    = 32,
  parameter vaddr_t BASE      = DEF_BASE,
  parameter vaddr_t STRIDE    = DEF_STRIDE,
  localparam int    IDX_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
  localparam int    CNT_W     = $clog2(NUM_SLOTS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_req_i,
  output logic              alloc_gnt_o,
  output logic [IDX_W-1:0]  alloc_idx_o,
  output logic [ADDR_W-1:0] alloc_vaddr_o,
  input  logic              free_valid_i,
  input  logic [IDX_W-1:0]  free_idx_i,
  output logic              free_err_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic              empty_o
);

  typedef logic [NUM_SLOTS-1:0][ADDR_W-1:0] table_t;

  function automatic table_t build_table();
    table_t t;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      t[i] = ADDR_W'(slot_addr(BASE, STRIDE, i));
    end
    return t;
  endfunction

  localparam table_t TABLE = build_table();

`ifdef VADDR_SLOT_ELAB_CHECK_EN
  if (NUM_SLOTS < 1) begin : g_bad_num
    $fatal(1, "vaddr_slot_alloc: NUM_SLOTS must be >= 1 (slot 0 missing)");
  end else begin : g_chk
    if ((slot_addr(BASE, STRIDE, NUM_SLOTS - 1) >> ADDR_W) != '0) begin : g_bad_range
      $fatal(1, "vaddr_slot_alloc: slot %0d address exceeds ADDR_W", NUM_SLOTS - 1);
    end
    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_entry
      if (TABLE[g] != ADDR_W'(BASE + vaddr_t'(g) * STRIDE)) begin : g_bad_entry
        $fatal(1, "vaddr_slot_alloc: table entry for slot %0d is wrong", g);
      end
    end
  end
`endif

  logic [NUM_SLOTS-1:0]    busy;
  logic [(1<<IDX_W)-1:0]   busy_pad;
  logic [IDX_W-1:0]        sel_idx;
  logic                    any_free;
  logic                    alloc_ok;
  logic                    free_ok;

  vaddr_slot_prio_enc #(
    .N     (NUM_SLOTS),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .vec   (~busy),
    .idx   (sel_idx),
    .valid (any_free)
  );

  // Zero-padded view so an out-of-range free index reads as "not busy".
  always_comb begin
    busy_pad                = '0;
    busy_pad[NUM_SLOTS-1:0] = busy;
  end

  assign alloc_ok = alloc_req_i && any_free;
  assign free_ok  = free_valid_i && (32'(free_idx_i) < NUM_SLOTS) && busy_pad[free_idx_i];

  // Allocation picks from the pre-edge bitmap, so it never targets the slot
  // being freed in the same cycle; the two bit updates cannot collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy          <= '0;
      count_o       <= '0;
      alloc_gnt_o   <= 1'b0;
      alloc_idx_o   <= '0;
      alloc_vaddr_o <= '0;
      free_err_o    <= 1'b0;
    end else begin
      if (free_ok) busy[free_idx_i] <= 1'b0;
      if (alloc_ok) begin
        busy[sel_idx] <= 1'b1;
        alloc_idx_o   <= sel_idx;
        alloc_vaddr_o <= TABLE[sel_idx];
      end
      count_o     <= count_o + CNT_W'(alloc_ok) - CNT_W'(free_ok);
      alloc_gnt_o <= alloc_ok;
      free_err_o  <= free_valid_i && !free_ok;
    end
  end

  assign full_o  = (count_o == CNT_W'(NUM_SLOTS));
  assign empty_o = (count_o == '0);

endmodule

// File: tb/tb_vaddr_slot_alloc.sv
// Scoreboard bench: a 4-slot default instance and a 5-slot 12-bit instance whose
// table wraps. Inputs change on the falling edge; outputs are sampled there too.
module tb_vaddr_slot_alloc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance a: defaults (4 slots, 0x1000 + i*0x100)
  logic        a_req = 0, a_fv = 0;
  logic [1:0]  a_fidx = 0;
  logic        a_gnt, a_err, a_full, a_empty;
  logic [1:0]  a_idx;
  logic [31:0] a_vaddr;
  logic [2:0]  a_cnt;

  vaddr_slot_alloc u_dut_a (
    .clk(clk), .rst(rst), .alloc_req_i(a_req), .alloc_gnt_o(a_gnt),
    .alloc_idx_o(a_idx), .alloc_vaddr_o(a_vaddr), .free_valid_i(a_fv),
    .free_idx_i(a_fidx), .free_err_o(a_err), .count_o(a_cnt),
    .full_o(a_full), .empty_o(a_empty)
  );

  // Instance b: 5 slots, 12-bit addresses, table F00,000,100,200,300
  logic        b_req = 0, b_fv = 0;
  logic [2:0]  b_fidx = 0;
  logic        b_gnt, b_err, b_full, b_empty;
  logic [2:0]  b_idx;
  logic [11:0] b_vaddr;
  logic [2:0]  b_cnt;

  vaddr_slot_alloc #(
    .NUM_SLOTS(5), .ADDR_W(12), .BASE(64'hF00), .STRIDE(64'h100)
  ) u_dut_b (
    .clk(clk), .rst(rst), .alloc_req_i(b_req), .alloc_gnt_o(b_gnt),
    .alloc_idx_o(b_idx), .alloc_vaddr_o(b_vaddr), .free_valid_i(b_fv),
    .free_idx_i(b_fidx), .free_err_o(b_err), .count_o(b_cnt),
    .full_o(b_full), .empty_o(b_empty)
  );

  // Scoreboard queues: {idx, vaddr} per expected grant, one entry per expected error.
  logic [33:0] a_gnt_q[$];
  logic [0:0]  a_err_q[$];
  logic [14:0] b_gnt_q[$];
  logic [0:0]  b_err_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: pop and compare whenever a DUT presents a pulse.
  always @(negedge clk) begin
    if (a_gnt === 1'b1) begin
      if (a_gnt_q.size() == 0) chk("a_unexpected_gnt", 1, 0);
      else chk("a_gnt_idx_vaddr", {a_idx, a_vaddr}, a_gnt_q.pop_front());
    end
    if (a_err === 1'b1) begin
      if (a_err_q.size() == 0) chk("a_unexpected_err", 1, 0);
      else chk("a_err", a_err, a_err_q.pop_front());
    end
    if (b_gnt === 1'b1) begin
      if (b_gnt_q.size() == 0) chk("b_unexpected_gnt", 1, 0);
      else chk("b_gnt_idx_vaddr", {b_idx, b_vaddr}, b_gnt_q.pop_front());
    end
    if (b_err === 1'b1) begin
      if (b_err_q.size() == 0) chk("b_unexpected_err", 1, 0);
      else chk("b_err", b_err, b_err_q.pop_front());
    end
  end

  // One cycle on instance a: drive, queue expectations, then check occupancy.
  task automatic cyc_a(input logic req, input logic fv, input logic [1:0] fi,
                       input logic eg, input logic [1:0] ei, input logic ee,
                       input int ec);
    a_req = req; a_fv = fv; a_fidx = fi;
    if (eg) a_gnt_q.push_back({ei, 32'h1000 + 32'h100 * 32'(ei)});
    if (ee) a_err_q.push_back(1'b1);
    @(negedge clk);
    chk("a_count", a_cnt, ec);
    chk("a_full", a_full, ec == 4);
    chk("a_empty", a_empty, ec == 0);
  endtask

  task automatic cyc_b(input logic req, input logic fv, input logic [2:0] fi,
                       input logic eg, input logic [2:0] ei, input logic [11:0] ev,
                       input logic ee, input int ec);
    b_req = req; b_fv = fv; b_fidx = fi;
    if (eg) b_gnt_q.push_back({ei, ev});
    if (ee) b_err_q.push_back(1'b1);
    @(negedge clk);
    chk("b_count", b_cnt, ec);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_gnt", a_gnt, 0);
    chk("rst_idx", a_idx, 0);
    chk("rst_vaddr", a_vaddr, 0);
    chk("rst_err", a_err, 0);
    chk("rst_count", a_cnt, 0);
    chk("rst_full", a_full, 0);
    chk("rst_empty", a_empty, 1);
    rst = 1'b0;

    // Fill all four slots with a held request.
    cyc_a(1, 0, 0, 1, 0, 0, 1);
    cyc_a(1, 0, 0, 1, 1, 0, 2);
    cyc_a(1, 0, 0, 1, 2, 0, 3);
    cyc_a(1, 0, 0, 1, 3, 0, 4);
    // Full: request plus free of slot 2 -> no grant, count drops.
    cyc_a(1, 1, 2, 0, 0, 0, 3);
    cyc_a(1, 0, 0, 1, 2, 0, 4);
    // Legal free of 1, then free of the now-idle slot 1 -> error pulse.
    cyc_a(0, 1, 1, 0, 0, 0, 3);
    cyc_a(0, 1, 1, 0, 0, 1, 3);
    cyc_a(0, 0, 0, 0, 0, 0, 3);
    chk("a_idx_hold", a_idx, 2);
    chk("a_vaddr_hold", a_vaddr, 32'h1200);
    // Reduce to slots 0,1 busy.
    cyc_a(0, 1, 2, 0, 0, 0, 2);
    cyc_a(0, 1, 3, 0, 0, 0, 1);
    cyc_a(1, 0, 0, 1, 1, 0, 2);
    // Alloc + free 0 together: grant 2, count unchanged, slot 0 freed next.
    cyc_a(1, 1, 0, 1, 2, 0, 2);
    cyc_a(1, 0, 0, 1, 0, 0, 3);
    cyc_a(1, 0, 0, 1, 3, 0, 4);
    // Free then reset mid back-to-back grants: pending grant suppressed.
    cyc_a(1, 1, 1, 0, 0, 0, 3);
    a_req = 1; rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_gnt", a_gnt, 0);
    chk("mid_rst_count", a_cnt, 0);
    chk("mid_rst_empty", a_empty, 1);
    rst = 1'b0;
    cyc_a(1, 0, 0, 1, 0, 0, 1);
    cyc_a(0, 0, 0, 0, 0, 0, 1);

    // Instance b: wrapped addresses and out-of-range free index.
    cyc_b(1, 0, 0, 1, 0, 12'hF00, 0, 1);
    cyc_b(1, 0, 0, 1, 1, 12'h000, 0, 2);
    cyc_b(0, 1, 5, 0, 0, 12'h000, 1, 2);
    cyc_b(0, 1, 1, 0, 0, 12'h000, 0, 1);
    cyc_b(0, 0, 0, 0, 0, 12'h000, 0, 1);
    chk("b_full", b_full, 0);
    chk("b_empty", b_empty, 0);

    repeat (2) @(negedge clk);
    chk("a_gnt_q_drained", a_gnt_q.size(), 0);
    chk("a_err_q_drained", a_err_q.size(), 0);
    chk("b_gnt_q_drained", b_gnt_q.size(), 0);
    chk("b_err_q_drained", b_err_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vaddr_slot_alloc.md
# vaddr_slot_alloc

Parametrised virtual-address slot allocator. Holds a NUM_SLOTS-entry table of virtual base addresses computed at elaboration by a static constant function, and hands out and reclaims those slots at run time through a request/grant and free interface. Sits between the request front-end and any unit that needs a unique per-transaction virtual address window. Optionally self-checks the elaborated table with fatal elaboration errors.

## Interface
- NUM_SLOTS, 4, number of address slots (≥1)
- ADDR_W, 32, width of each virtual address
- BASE, 32'h0000_1000, address of slot 0
- STRIDE, 32'h0000_0100, address increment per slot
- IDX_W (localparam), $clog2(NUM_SLOTS) with minimum 1, slot index width
- CNT_W (localparam), $clog2(NUM_SLOTS+1), occupancy counter width

- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- alloc_req_i  in  1  request one slot this cycle
- alloc_gnt_o  out  1  registered one-cycle grant pulse
- alloc_idx_o  out  IDX_W  granted slot index, valid with alloc_gnt_o
- alloc_vaddr_o  out  ADDR_W  granted slot address, valid with alloc_gnt_o
- free_valid_i  in  1  return a slot this cycle
- free_idx_i  in  IDX_W  slot being returned
- free_err_o  out  1  registered one-cycle pulse: illegal free
- count_o  out  CNT_W  number of slots currently allocated
- full_o  out  1  count_o == NUM_SLOTS
- empty_o  out  1  count_o == 0

## Operation
- Table: localparam array of NUM_SLOTS × ADDR_W, filled by a static function looping i = 0..NUM_SLOTS-1, entry[i] = BASE + i*STRIDE, truncated to ADDR_W.
- State: busy bitmap (NUM_SLOTS bits), count register, output registers.
- Allocate: alloc_req_i=1 and bitmap not all busy → lowest-index free slot set busy; next cycle alloc_gnt_o=1 with its idx/vaddr. One grant per cycle max; held request yields consecutive grants until full.
- alloc_req_i=1 while full → no grant, no state change, request not queued.
- Free: free_valid_i=1, free_idx_i < NUM_SLOTS and busy → bit cleared. Free of an idle slot or free_idx_i ≥ NUM_SLOTS → no state change, free_err_o=1 next cycle.
- Same-cycle alloc and free: allocation selects from the pre-edge bitmap; a slot freed this cycle is not grantable until the next cycle. Both take effect; count unchanged. Full plus free in same cycle: no grant, count decrements.
- count_o updated +1 per grant, −1 per legal free; never wraps.
- alloc_idx_o/alloc_vaddr_o hold last granted values when alloc_gnt_o=0.

## Timing
- Grant latency: 1 cycle from request edge. Free latency: bitmap/count updated at the same edge; free_err_o 1 cycle later.
- full_o/empty_o combinational from count_o register.
- Reset values: bitmap all free, count_o 0, alloc_gnt_o 0, alloc_idx_o 0, alloc_vaddr_o 0, free_err_o 0, full_o 0, empty_o 1.
- Reset mid-operation: all slots freed; any grant/err pulse that would appear next cycle is suppressed; rst dominates alloc and free.

## Configuration
- VADDR_SLOT_ELAB_CHECK_EN defined: generate-time checks per entry that table[i] == BASE + i*STRIDE; also NUM_SLOTS ≥ 1 and BASE + (NUM_SLOTS-1)*STRIDE < 2**ADDR_W. Any failure → $fatal(1, message naming the slot index).
- Undefined: no checks; addresses wrap modulo 2**ADDR_W silently. Runtime behaviour identical.

## Structure
- Package vaddr_slot_pkg: vaddr_t parametrised typedef helper, static table-builder function, default BASE/STRIDE constants.
- Sub-module vaddr_slot_prio_enc: NUM_SLOTS-wide lowest-set-bit finder returning index and any-valid flag, used on the inverted bitmap.

## Test plan
- Reset, NUM_SLOTS=4: hold alloc_req_i 4 cycles → grants idx 0..3, vaddr 0x1000,0x1100,0x1200,0x1300; then full_o=1, count_o=4.
- Full, alloc_req_i=1 → no alloc_gnt_o; free idx 2 same cycle → count_o=3, next-cycle request grants idx 2 / 0x1200.
- Free idx 1 when idle → free_err_o pulse one cycle, count_o unchanged; free_idx_i=5 with NUM_SLOTS=5 → free_err_o.
- count_o=2 (slots 0,1 busy), alloc and free idx 0 same cycle → grant idx 2, count_o stays 2, slot 0 free.
- Assert rst during back-to-back grants → next cycle alloc_gnt_o=0, count_o=0, empty_o=1; next request grants idx 0.
- With VADDR_SLOT_ELAB_CHECK_EN, ADDR_W=12, BASE=0xF00, STRIDE=0x100, NUM_SLOTS=4 → elaboration $fatal; without macro slot 1 vaddr = 0x000.
